// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: single-clock AXI4-Stream FIFO on an inferred simple-dual-port
// RAM, with a first-word-fall-through output buffer that hides the RAM read
// latency, plus occupancy count and almost-full/almost-empty flags.
module axis_sync_fifo #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned DEPTH           = 512,
  parameter string       RAM_PERFORMANCE = "LOW_LATENCY",
  parameter int unsigned ALMOST_FULL_TH  = DEPTH - 4,
  parameter int unsigned ALMOST_EMPTY_TH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
  input  logic                         s_axis_tlast,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [$clog2(DEPTH)+1:0]     data_count,
  output logic                         almost_full,
  output logic                         almost_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned L  = (RAM_PERFORMANCE == "HIGH_PERFORMANCE") ? 2 : 1;
  localparam int unsigned OB = L + 1;
  localparam int unsigned W  = DATA_WIDTH + 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   ram_count;
  logic          wr_fire;
  logic          issue;
  logic          pop;
  logic          push;
  logic [L-1:0]  vld;
  logic [W-1:0]  ram_q;
  logic [W-1:0]  push_word;
  logic [W-1:0]  ob [OB];
  logic [1:0]    obuf_count;
  logic [1:0]    inflight;
  logic [2:0]    credit_used;
  int unsigned   push_idx;

  assign ram_count     = wr_ptr - rd_ptr;
  assign s_axis_tready = !rst && (ram_count != FULL_CNT);
  assign wr_fire       = s_axis_tvalid && s_axis_tready;

  assign m_axis_tvalid = (obuf_count != 2'd0);
  assign m_axis_tdata  = ob[0][DATA_WIDTH-1:0];
  assign m_axis_tlast  = ob[0][DATA_WIDTH];
  assign pop           = m_axis_tvalid && m_axis_tready;

  // Count read tokens still travelling through the RAM latency pipe.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < L; i++) inflight = inflight + 2'(vld[i]);
  end

  // Credit check: obuf slots already claimed (held plus in flight, less this
  // cycle's pop) must leave room for one more word before a read is issued.
  always_comb begin
    credit_used = 3'(obuf_count) + 3'(inflight) - 3'(pop);
    issue       = (ram_count != '0) && (credit_used < 3'(OB));
    push_idx    = 32'(obuf_count) - 32'(pop);
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
  end

  // RAM read port, first (and for low latency, only) output register.
  always_ff @(posedge clk) begin
    if (issue) ram_q <= mem[rd_ptr[AW-1:0]];
  end

  // Write and read pointers; the extra MSB is the wrap bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (issue)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  generate
    if (L == 1) begin : g_lat1
      // Token marks that ram_q holds a freshly read word.
      always_ff @(posedge clk) begin
        if (rst) vld[0] <= 1'b0;
        else     vld[0] <= issue;
      end
      assign push      = vld[0];
      assign push_word = ram_q;
    end else begin : g_lat2
      logic [W-1:0] ram_q2;
      // Registered RAM output stage.
      always_ff @(posedge clk) begin
        if (vld[0]) ram_q2 <= ram_q;
      end
      // Two-stage token pipe tracking reads through both registers.
      always_ff @(posedge clk) begin
        if (rst) vld <= '0;
        else     vld <= {vld[0], issue};
      end
      assign push      = vld[1];
      assign push_word = ram_q2;
    end
  endgenerate

  // Output buffer as a shift register: head at entry 0, a push lands just
  // behind the last word that survives this cycle's pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < OB; i++) ob[i] <= '0;
      obuf_count <= '0;
    end else begin
      if (pop) begin
        for (int unsigned i = 0; i < OB - 1; i++) ob[i] <= ob[i+1];
      end
      if (push) begin
        for (int unsigned i = 0; i < OB; i++) begin
          if (i == push_idx) ob[i] <= push_word;
        end
      end
      obuf_count <= obuf_count + 2'(push) - 2'(pop);
    end
  end

  // Occupancy: words accepted on the slave side and not yet delivered.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_count <= '0;
    end else begin
      case ({wr_fire, pop})
        2'b10:   data_count <= data_count + 1'b1;
        2'b01:   data_count <= data_count - 1'b1;
        default: data_count <= data_count;
      endcase
    end
  end

  assign almost_full  = (32'(data_count) >= ALMOST_FULL_TH);
  assign almost_empty = (32'(data_count) <= ALMOST_EMPTY_TH);

endmodule

// File: doc/axis_sync_fifo.md
# axis_sync_fifo

Single-clock AXI4-Stream FIFO built on an inferred simple-dual-port block RAM. Depth, width and RAM read latency (1 or 2 cycles) are parametrised. A first-word-fall-through output buffer hides the RAM read latency, so the block sustains one word per cycle. It sits in `utils/axis_fifo` as the general-purpose stream buffer between datapath blocks, and adds occupancy count and almost-full/almost-empty flags.

## Interface
- `DATA_WIDTH`, default 32: payload width. `tlast` is stored alongside it as one extra RAM bit.
- `DEPTH`, default 512: RAM entries. Must be a power of 2, ≥4. `AW = clog2(DEPTH)`.
- `RAM_PERFORMANCE`, default "LOW_LATENCY": "LOW_LATENCY" gives RAM read latency L=1; "HIGH_PERFORMANCE" gives L=2 (registered RAM output).
- `ALMOST_FULL_TH`, default DEPTH-4: `almost_full` threshold.
- `ALMOST_EMPTY_TH`, default 4: `almost_empty` threshold.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_axis_tdata`  in  DATA_WIDTH  write payload.
- `s_axis_tlast`  in  1  write packet end.
- `s_axis_tvalid`  in  1  write valid.
- `s_axis_tready`  out  1  space available in RAM.
- `m_axis_tdata`  out  DATA_WIDTH  read payload (FWFT).
- `m_axis_tlast`  out  1  read packet end.
- `m_axis_tvalid`  out  1  head word present.
- `m_axis_tready`  in  1  consumer accepts.
- `data_count`  out  AW+2  words accepted but not yet delivered: RAM, plus in-flight reads, plus output buffer.
- `almost_full`  out  1  `data_count >= ALMOST_FULL_TH`.
- `almost_empty`  out  1  `data_count <= ALMOST_EMPTY_TH`.

## Operation
- **Pointers.** `wr_ptr` and `rd_ptr` are AW+1 bits; the MSB is the wrap bit.
  - `ram_count = wr_ptr - rd_ptr`, range 0..DEPTH.
  - `s_axis_tready = !rst && ram_count != DEPTH`.
- **Write.** On `s_axis_tvalid && s_axis_tready`, `{tlast,tdata}` is written at `wr_ptr[AW-1:0]` and `wr_ptr` increments. It wraps naturally at 2·DEPTH.
- **Output buffer.**
  - The output buffer (obuf) is a small register FIFO of L+1 entries; its head drives the `m_axis_*` outputs.
  - `m_axis_tvalid` = obuf non-empty.
  - A pop occurs on `m_axis_tvalid && m_axis_tready`.
- **Read issue.** A RAM read is issued when both hold:
  - `ram_count > 0`;
  - `obuf_count + inflight - pop < L+1`.
  - On issue, `rd_ptr` increments, and a valid token enters an L-stage shift pipe. The token's word is pushed into obuf when it exits the pipe.
  - This credit rule guarantees that obuf never overflows.
- **No read-during-write hazard.** Reads use the registered `wr_ptr`, so a word written at edge t is readable no earlier than the cycle after edge t.
- **Count.** `data_count` is incremented on a write handshake and decremented on a pop. Both in the same cycle leave it unchanged. Range 0..DEPTH+L+1.
- **Flags.** `almost_full` and `almost_empty` are combinational compares on the registered `data_count`.
- **Reset (`rst`=1 at an edge).** Clears `wr_ptr`, `rd_ptr`, the pipe tokens, obuf and `data_count`. Words in flight are discarded. RAM contents are not cleared.
- **Outputs during and after reset.** `s_axis_tready` = 0 while `rst` is high. After reset:
  - `m_axis_tvalid` = 0, `m_axis_tdata` = 0, `m_axis_tlast` = 0;
  - `data_count` = 0, `almost_full` = 0, `almost_empty` = 1.
- **Mid-operation reset.** Behaves identically to reset; no partial word is emitted afterwards.

## Timing
- **Empty-FIFO latency.** A write handshake at edge t makes the word visible with `m_axis_tvalid` = 1 after edge t+1+L. That is 2 cycles for LOW_LATENCY and 3 for HIGH_PERFORMANCE.
- **Throughput.** With `s_axis_tvalid` = `m_axis_tready` = 1 continuously, one word per cycle passes after the initial latency, with no bubbles.
- **Backpressure.** `m_axis_tdata` and `m_axis_tlast` are held stable while `m_axis_tvalid && !m_axis_tready` (AXIS rule).
- **Full.** `s_axis_tready` drops in the cycle after the write that makes `ram_count` = DEPTH. It rises in the cycle after the next read issue.
- **Capacity.** Maximum stored words = DEPTH+L+1 (RAM full plus obuf full).
- **Simultaneous events.**
  - A write and a read issue in the same cycle at full are legal: the write is blocked and the read frees a slot for the next cycle.
  - A write and a pop on the same edge leave `data_count` unchanged.
- **Ordering.** Strict FIFO order, with `tlast` bound to its word.

## Test plan
- **Single-word latency.** DEPTH=16, WIDTH=16, both modes. Write 0xA5A5 with `tlast`=1 on an empty FIFO → `m_axis_tvalid` high exactly 2 (LL) or 3 (HP) cycles after the write edge, data 0xA5A5, `tlast`=1, `data_count` 1 then 0 after the pop.
- **Fill to capacity.** With `m_axis_tready` = 0, write the incrementing sequence 0..40.
  - Accepted: DEPTH+L+1 words (18 LL / 19 HP).
  - `s_axis_tready` low afterwards; `data_count` = 18/19; `almost_full` high from `data_count` 12; `almost_empty` low from 5.
  - Drain with `tready` = 1 → words 0..17/18 emitted in order with no gaps.
- **Streaming.** Continuous valid/ready for 100 words crossing the pointer wrap several times → output equals input, 1 word/cycle, `data_count` constant at steady state.
- **Random backpressure.** Random `tvalid` and `tready` at 50% each for 2000 words → scoreboard match, `tdata` and `tlast` stable while stalled, no obuf overflow (assertion).
- **Mid-stream reset.** Assert `rst` for 1 cycle while 10 words are held → next cycle `m_axis_tvalid` = 0, `data_count` = 0, `almost_empty` = 1. A subsequent write of 0x1234 emerges alone with the correct latency.
